// File: rtl/tok_hash_table.sv
// Linear-probe key/value table (LOOKUP / INSERT / CLEAR) backed by synchronous RAM.
// Optional occupancy counter and fast FULL path: define TOK_TABLE_STATS_EN.
module tok_hash_table #(
  parameter int KEY_W     = 16,
  parameter int VAL_W     = 16,
  parameter int IDX_W     = 8,
  parameter int MAX_PROBE = 2**IDX_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [KEY_W-1:0] req_key,
  input  logic [VAL_W-1:0] req_val,
  output logic             rsp_valid,
  output logic [1:0]       rsp_status,
  output logic [VAL_W-1:0] rsp_val,
  output logic [IDX_W-1:0] rsp_idx
`ifdef TOK_TABLE_STATS_EN
  ,
  output logic [IDX_W:0]   count
`endif
);

  localparam int SLOTS = 2**IDX_W;
  localparam logic [IDX_W:0] PROBE_LIM = (IDX_W+1)'(MAX_PROBE);

  localparam logic [1:0] OP_INSERT = 2'b01;
  localparam logic [1:0] OP_CLEAR  = 2'b10;
  localparam logic [1:0] ST_MISS   = 2'b00;
  localparam logic [1:0] ST_HIT    = 2'b01;
  localparam logic [1:0] ST_FULL   = 2'b10;
  localparam logic [1:0] ST_BADKEY = 2'b11;

  typedef enum logic [2:0] {SWEEP, IDLE, RD, CMP, RESP} state_t;

  typedef struct packed {
    logic [1:0]       op;
    logic [KEY_W-1:0] key;
    logic [VAL_W-1:0] val;
  } req_t;

  state_t           state, state_n;
  req_t             rq;
  logic [IDX_W-1:0] idx, sweep_idx;
  logic [IDX_W:0]   probe, probe_n;
  logic             sweep_clr;

  logic [KEY_W-1:0] key_mem [0:SLOTS-1];
  logic [VAL_W-1:0] val_mem [0:SLOTS-1];
  logic [KEY_W-1:0] rd_key;
  logic [VAL_W-1:0] rd_val;

  logic             we;
  logic [IDX_W-1:0] waddr;
  logic [KEY_W-1:0] wkey;
  logic [VAL_W-1:0] wval;

  logic             rsp_load;
  logic [1:0]       st_n;
  logic [VAL_W-1:0] val_n;
  logic [IDX_W-1:0] ridx_n;

  logic op_ins, hit, empty, exhausted, tbl_full;

  assign req_ready = (state == IDLE);
  assign op_ins    = (rq.op == OP_INSERT);
  assign hit       = (rd_key == rq.key);
  assign empty     = (rd_key == '0);
  assign probe_n   = probe + 1'b1;
  assign exhausted = (probe_n == PROBE_LIM);

  // Storage has no reset; the post-reset sweep is what initialises it.
  always_ff @(posedge clk) begin
    if (we) begin
      key_mem[waddr] <= wkey;
      val_mem[waddr] <= wval;
    end
    if (state == RD) begin
      rd_key <= key_mem[idx];
      rd_val <= val_mem[idx];
    end
  end

  always_comb begin
    state_n  = state;
    we       = 1'b0;
    waddr    = idx;
    wkey     = rq.key;
    wval     = rq.val;
    rsp_load = 1'b0;
    st_n     = ST_MISS;
    val_n    = '0;
    ridx_n   = idx;
    case (state)
      SWEEP: begin
        we    = 1'b1;
        waddr = sweep_idx;
        wkey  = '0;
        wval  = '0;
        if (&sweep_idx) begin
          if (sweep_clr) begin
            state_n  = RESP;
            rsp_load = 1'b1;
            ridx_n   = '0;
          end else begin
            state_n = IDLE;
          end
        end
      end
      IDLE: if (req_valid) begin
        if (req_op == OP_CLEAR) begin
          state_n = SWEEP;
        end else if (req_key == '0) begin
          state_n  = RESP;
          rsp_load = 1'b1;
          st_n     = ST_BADKEY;
          ridx_n   = '0;
        end else if (req_op == OP_INSERT && tbl_full) begin
          // Full table: INSERT answered FULL straight away, no probing.
          state_n  = RESP;
          rsp_load = 1'b1;
          st_n     = ST_FULL;
          ridx_n   = '0;
        end else begin
          state_n = RD;
        end
      end
      RD: state_n = CMP;
      CMP: begin
        if (hit) begin
          state_n  = RESP;
          rsp_load = 1'b1;
          st_n     = ST_HIT;
          we       = op_ins;
          if (!op_ins) val_n = rd_val;
        end else if (empty) begin
          state_n  = RESP;
          rsp_load = 1'b1;
          we       = op_ins;
        end else if (exhausted) begin
          state_n  = RESP;
          rsp_load = 1'b1;
          st_n     = op_ins ? ST_FULL : ST_MISS;
          if (op_ins) ridx_n = '0;
        end else begin
          state_n = RD;
        end
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= SWEEP;
      sweep_idx  <= '0;
      sweep_clr  <= 1'b0;
      rq         <= '0;
      idx        <= '0;
      probe      <= '0;
      rsp_valid  <= 1'b0;
      rsp_status <= ST_MISS;
      rsp_val    <= '0;
      rsp_idx    <= '0;
    end else begin
      state <= state_n;
      if (state == SWEEP) sweep_idx <= sweep_idx + 1'b1;
      if (state == SWEEP && (&sweep_idx)) sweep_clr <= 1'b0;
      if (state == IDLE && req_valid) begin
        rq    <= '{op: req_op, key: req_key, val: req_val};
        idx   <= req_key[IDX_W-1:0];
        probe <= '0;
        if (req_op == OP_CLEAR) sweep_clr <= 1'b1;
      end
      if (state == CMP && state_n == RD) begin
        probe <= probe_n;
        idx   <= idx + 1'b1;
      end
      rsp_valid <= rsp_load;
      if (rsp_load) begin
        rsp_status <= st_n;
        rsp_val    <= val_n;
        rsp_idx    <= ridx_n;
      end
    end
  end

`ifdef TOK_TABLE_STATS_EN
  localparam logic [IDX_W:0] FULL_CNT = (IDX_W+1)'(SLOTS);
  assign tbl_full = (count == FULL_CNT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (state == IDLE && req_valid && req_op == OP_CLEAR) begin
      count <= '0;
    end else if (state == CMP && op_ins && !hit && empty) begin
      count <= count + 1'b1;
    end
  end
`else
  assign tbl_full = 1'b0;
`endif

endmodule

// File: tb/tb_tok_hash_table.sv
// Bench for tok_hash_table at IDX_W=4, MAX_PROBE=16: vector table + scoreboard queue.
module tb_tok_hash_table;
  localparam int KW = 16, VW = 16, IW = 4, MP = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [1:0]    req_op = 2'b00;
  logic [KW-1:0] req_key = '0;
  logic [VW-1:0] req_val = '0;
  logic          rsp_valid;
  logic [1:0]    rsp_status;
  logic [VW-1:0] rsp_val;
  logic [IW-1:0] rsp_idx;
`ifdef TOK_TABLE_STATS_EN
  logic [IW:0]   count;
`endif

  always #5 clk = ~clk;

  tok_hash_table #(.KEY_W(KW), .VAL_W(VW), .IDX_W(IW), .MAX_PROBE(MP)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_key(req_key), .req_val(req_val),
    .rsp_valid(rsp_valid), .rsp_status(rsp_status), .rsp_val(rsp_val), .rsp_idx(rsp_idx)
`ifdef TOK_TABLE_STATS_EN
    , .count(count)
`endif
  );

  typedef struct {
    logic [1:0]  op;
    logic [15:0] key;
    logic [15:0] val;
    logic [1:0]  st;
    logic [15:0] rval;
    logic [3:0]  ridx;
    int          lat;
  } vec_t;

  typedef struct {
    logic [1:0]  st;
    logic [15:0] val;
    logic [3:0]  idx;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  vec_t tv[13];
  int   n_cmp = 0;
  int   n_bad = 0;

  localparam logic [1:0] LK = 2'b00, IN = 2'b01, CL = 2'b10, RS = 2'b11;
  localparam logic [1:0] MISS = 2'b00, HIT = 2'b01, FULL = 2'b10, BAD = 2'b11;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Scoreboard: every response pops the oldest expectation.
  always @(negedge clk) begin
    if (reset && rsp_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("rsp_status", {30'd0, rsp_status}, {30'd0, mon_e.st});
        chk("rsp_val", {16'd0, rsp_val}, {16'd0, mon_e.val});
        chk("rsp_idx", {28'd0, rsp_idx}, {28'd0, mon_e.idx});
      end
    end
  end

  task automatic send(input logic [1:0] op, input logic [15:0] key, input logic [15:0] val,
                      input logic [1:0] st, input logic [15:0] rval, input logic [3:0] ridx,
                      input int lat);
    int w, l;
    exp_t e;
    @(negedge clk);
    w = 0;
    while (!req_ready && w < 100) begin @(negedge clk); w++; end
    if (!req_ready) begin chk("ready_timeout", 32'd0, 32'd1); return; end
    e.st = st; e.val = rval; e.idx = ridx;
    sb.push_back(e);
    req_valid = 1'b1; req_op = op; req_key = key; req_val = val;
    @(posedge clk);
    #1 req_valid = 1'b0;
    l = 0;
    do begin @(negedge clk); l++; end while (!rsp_valid && l < 200);
    chk("latency", l, lat);
    if (!rsp_valid && sb.size() != 0) void'(sb.pop_back());
  endtask

  task automatic check_ready_after_reset();
    int n;
    n = 0;
    while (!req_ready && n < 100) begin @(negedge clk); n++; end
    chk("sweep_cycles", n, 32'd16);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, {31'd0, req_ready}, 32'd0);
    chk({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    chk({tag, "_rsp_status"}, {30'd0, rsp_status}, 32'd0);
    chk({tag, "_rsp_val"}, {16'd0, rsp_val}, 32'd0);
    chk({tag, "_rsp_idx"}, {28'd0, rsp_idx}, 32'd0);
  endtask

  initial begin
    tv[0]  = '{LK, 16'h1234, 16'h0000, MISS, 16'h0000, 4'd4, 3};
    tv[1]  = '{IN, 16'h0013, 16'hAAAA, MISS, 16'h0000, 4'd3, 3};
    tv[2]  = '{LK, 16'h0013, 16'h0000, HIT,  16'hAAAA, 4'd3, 3};
    tv[3]  = '{IN, 16'h0023, 16'hBBBB, MISS, 16'h0000, 4'd4, 5};
    tv[4]  = '{IN, 16'h0023, 16'hCCCC, HIT,  16'h0000, 4'd4, 5};
    tv[5]  = '{LK, 16'h0023, 16'h0000, HIT,  16'hCCCC, 4'd4, 5};
    tv[6]  = '{IN, 16'h001F, 16'h1111, MISS, 16'h0000, 4'd15, 3};
    tv[7]  = '{IN, 16'h002F, 16'h2222, MISS, 16'h0000, 4'd0, 5};
    tv[8]  = '{LK, 16'h002F, 16'h0000, HIT,  16'h2222, 4'd0, 5};
    tv[9]  = '{LK, 16'h0000, 16'h0000, BAD,  16'h0000, 4'd0, 1};
    tv[10] = '{IN, 16'h0000, 16'h5555, BAD,  16'h0000, 4'd0, 1};
    tv[11] = '{RS, 16'h0013, 16'h0000, HIT,  16'hAAAA, 4'd3, 3};
    tv[12] = '{LK, 16'h0033, 16'h0000, MISS, 16'h0000, 4'd5, 7};

    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    reset = 1'b1;
    check_ready_after_reset();

    foreach (tv[i])
      send(tv[i].op, tv[i].key, tv[i].val, tv[i].st, tv[i].rval, tv[i].ridx, tv[i].lat);

    // Outputs hold between pulses.
    repeat (3) @(negedge clk);
    chk("hold_valid", {31'd0, rsp_valid}, 32'd0);
    chk("hold_idx", {28'd0, rsp_idx}, 32'd5);

    // Fill the 12 remaining slots with keys homing exactly on them.
    for (int s = 0; s < 16; s++) begin
      if (s != 0 && s != 3 && s != 4 && s != 15)
        send(IN, 16'h0100 | 16'(s), 16'h5000 | 16'(s), MISS, 16'h0000, 4'(s), 3);
    end
`ifdef TOK_TABLE_STATS_EN
    chk("count_full", {27'd0, count}, 32'd16);
    send(IN, 16'h0099, 16'h9999, FULL, 16'h0000, 4'd0, 1);
`else
    send(IN, 16'h0099, 16'h9999, FULL, 16'h0000, 4'd0, 33);
`endif
    send(LK, 16'h0099, 16'h0000, MISS, 16'h0000, 4'd8, 33);
    send(LK, 16'h0013, 16'h0000, HIT, 16'hAAAA, 4'd3, 3);
    send(LK, 16'h0108, 16'h0000, HIT, 16'h5008, 4'd8, 3);

    send(CL, 16'h0000, 16'h0000, MISS, 16'h0000, 4'd0, 17);
    send(LK, 16'h0013, 16'h0000, MISS, 16'h0000, 4'd3, 3);

    // Reset 5 cycles into a CLEAR: no response, fresh sweep.
    send(IN, 16'h0013, 16'hAAAA, MISS, 16'h0000, 4'd3, 3);
    @(negedge clk);
    req_valid = 1'b1; req_op = CL; req_key = '0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    #1 check_reset_outputs("midclr");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    check_ready_after_reset();
    send(LK, 16'h0013, 16'h0000, MISS, 16'h0000, 4'd3, 3);

    repeat (2) @(negedge clk);
    chk("sb_empty", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
endmodule
